// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: one WIDTH-bit operation evaluated LSB first through a single 1-bit slice,
// with a registered carry looping back each cycle. start/done handshake, registered result and flags.
//   state  | meaning
//   IDLE   | waiting for start; operands captured on accept
//   RUN    | one bit per cycle, index 0..WIDTH-1
//   DONE   | one-cycle done pulse; start here is accepted for back-to-back ops
module bit_serial_alu #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    localparam logic [2:0] OP_PASSB = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [IW-1:0]    r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_shift;

    logic [WIDTH-1:0] r_result;
    logic             r_negative;
    logic             r_zero;
    logic             r_overflow;
    logic             r_carry_out;

    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_b_eff;
    logic             w_sum;
    logic             w_slice_c;
    logic             w_slice_r;
    logic             w_arith;
    logic [WIDTH-1:0] w_shift_next;

    assign w_last = (r_state == S_RUN) && (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Single 1-bit slice; subtract inverts B and relies on the carry preloaded to 1.
    always_comb begin
        w_a_bit   = r_a[r_idx];
        w_b_bit   = r_b[r_idx];
        w_b_eff   = w_b_bit ^ (r_op == OP_SUB);
        w_sum     = w_a_bit ^ w_b_eff ^ r_carry;
        w_slice_c = (w_a_bit & w_b_eff) | (w_a_bit & r_carry) | (w_b_eff & r_carry);
        w_slice_r = 1'b0;
        case (r_op)
            OP_PASSB: w_slice_r = w_b_bit;
            OP_ADD:   w_slice_r = w_sum;
            OP_SUB:   w_slice_r = w_sum;
            OP_AND:   w_slice_r = w_a_bit & w_b_bit;
            OP_OR:    w_slice_r = w_a_bit | w_b_bit;
            OP_XOR:   w_slice_r = w_a_bit ^ w_b_bit;
            default:  w_slice_r = 1'b0;
        endcase
    end

    assign w_arith      = (r_op == OP_ADD) || (r_op == OP_SUB);
    assign w_shift_next = {w_slice_r, r_shift[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_shift     <= '0;
            r_result    <= '0;
            r_negative  <= 1'b0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_carry_out <= 1'b0;
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= B;
            r_op    <= cntrl;
            r_idx   <= '0;
            r_carry <= (cntrl == OP_SUB);
            r_shift <= '0;
        end else if (r_state == S_RUN) begin
            r_shift <= w_shift_next;
            r_carry <= w_slice_c;
            if (w_last) begin
                // On the MSB cycle r_carry is the carry into the MSB, w_slice_c the carry out.
                r_result    <= w_shift_next;
                r_negative  <= w_slice_r;
                r_zero      <= ~|w_shift_next;
                r_overflow  <= w_arith & (r_carry ^ w_slice_c);
                r_carry_out <= w_arith & w_slice_c;
            end else begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign result    = r_result;
    assign negative  = r_negative;
    assign zero      = r_zero;
    assign overflow  = r_overflow;
    assign carry_out = r_carry_out;

endmodule

// File: tb/tb_bit_serial_alu.sv
// Directed bench for bit_serial_alu (WIDTH=64): latency, arithmetic/logic results, flags,
// ignored start while busy, back-to-back start in DONE, and asynchronous abort.
module tb_bit_serial_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] A;
    logic [63:0] B;
    logic [2:0]  cntrl;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carry_out;

    int n_cmp = 0;
    int n_mis = 0;

    bit_serial_alu #(.WIDTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .A         (A),
        .B         (B),
        .cntrl     (cntrl),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    // Launches one op (start high across one edge), optionally pulses a stray start with other
    // operands at RUN cycle gcyc, and returns busy-cycle count, edges-to-done and first busy sample.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                          input int gcyc, output int nb, output int lat, output logic fb);
        A = a; B = b; cntrl = op; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        fb  = busy;
        nb  = 0;
        lat = 0;
        while (!done && lat < 200) begin
            if (busy) nb++;
            if (lat == gcyc) begin
                start = 1'b1; A = ~a; B = 64'h0; cntrl = 3'b010;
            end else if (lat == gcyc + 1) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; A = '0; B = '0; cntrl = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, negative, zero, overflow, carry_out} !== 6'b0) begin
            n_mis++;
            $display("FAIL reset_ctrl_flags: got %b want 000000", {busy, done, negative, zero, overflow, carry_out});
        end
        n_cmp++;
        if (result !== 64'h0) begin n_mis++; $display("FAIL reset_result: got %h want 0", result); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int nb, lat; logic fb;
        run_op(64'd5, 64'd3, 3'b010, -1, nb, lat, fb);
        n_cmp++;
        if (nb !== 64) begin n_mis++; $display("FAIL add_busy_cycles: got %0d want 64", nb); end
        n_cmp++;
        if (lat !== 64) begin n_mis++; $display("FAIL add_latency: got %0d want 64", lat); end
        n_cmp++;
        if (result !== 64'd8) begin n_mis++; $display("FAIL add_result: got %h want 8", result); end
        n_cmp++;
        if ({negative, zero, overflow, carry_out} !== 4'b0000) begin
            n_mis++; $display("FAIL add_flags: got %b want 0000", {negative, zero, overflow, carry_out});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin n_mis++; $display("FAIL done_one_cycle: got %b want 00", {busy, done}); end
        n_cmp++;
        if (result !== 64'd8) begin n_mis++; $display("FAIL add_result_held: got %h want 8", result); end
    endtask

    task automatic test_sub_zero();
        int nb, lat; logic fb;
        run_op(64'd5, 64'd5, 3'b011, -1, nb, lat, fb);
        n_cmp++;
        if (result !== 64'd0) begin n_mis++; $display("FAIL sub_zero_result: got %h want 0", result); end
        n_cmp++;
        if ({negative, zero, overflow, carry_out} !== 4'b0101) begin
            n_mis++; $display("FAIL sub_zero_flags: got %b want 0101", {negative, zero, overflow, carry_out});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow_borrow();
        int nb, lat; logic fb;
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, -1, nb, lat, fb);
        n_cmp++;
        if (result !== 64'h8000_0000_0000_0000) begin
            n_mis++; $display("FAIL ovf_result: got %h want 8000000000000000", result);
        end
        n_cmp++;
        if ({negative, zero, overflow, carry_out} !== 4'b1010) begin
            n_mis++; $display("FAIL ovf_flags: got %b want 1010", {negative, zero, overflow, carry_out});
        end
        @(posedge clk); #1;
        run_op(64'd0, 64'd1, 3'b011, -1, nb, lat, fb);
        n_cmp++;
        if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_mis++; $display("FAIL borrow_result: got %h want ffffffffffffffff", result);
        end
        n_cmp++;
        if ({negative, zero, overflow, carry_out} !== 4'b1000) begin
            n_mis++; $display("FAIL borrow_flags: got %b want 1000", {negative, zero, overflow, carry_out});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_logic_ops();
        int nb, lat; logic fb;
        logic [63:0] ta [6];
        logic [63:0] tb [6];
        logic [2:0]  top [6];
        logic [63:0] tr [6];
        logic [3:0]  tf [6];
        ta[0] = 64'hFF00_FF00_1234_5678; tb[0] = 64'h8F0F_0000_FFFF_0000; top[0] = 3'b100;
        tr[0] = 64'h8F00_0000_1234_0000; tf[0] = 4'b1000;
        ta[1] = 64'h0000_0000_0000_00F0; tb[1] = 64'h0000_0000_0000_000F; top[1] = 3'b101;
        tr[1] = 64'h0000_0000_0000_00FF; tf[1] = 4'b0000;
        ta[2] = 64'd5;                   tb[2] = 64'd3;                   top[2] = 3'b001;
        tr[2] = 64'h0;                   tf[2] = 4'b0100;
        ta[3] = 64'hFFFF_FFFF_FFFF_FFFF; tb[3] = 64'hFFFF_FFFF_FFFF_FFFF; top[3] = 3'b111;
        tr[3] = 64'h0;                   tf[3] = 4'b0100;
        ta[4] = 64'hFFFF_FFFF_FFFF_FFFF; tb[4] = 64'd1;                   top[4] = 3'b010;
        tr[4] = 64'h0;                   tf[4] = 4'b0101;
        ta[5] = 64'hDEAD_BEEF_0000_0001; tb[5] = 64'hDEAD_BEEF_0000_0001; top[5] = 3'b110;
        tr[5] = 64'h0;                   tf[5] = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb[i], top[i], -1, nb, lat, fb);
            n_cmp++;
            if (result !== tr[i]) begin
                n_mis++; $display("FAIL logic_result[%0d]: got %h want %h", i, result, tr[i]);
            end
            n_cmp++;
            if ({negative, zero, overflow, carry_out} !== tf[i]) begin
                n_mis++; $display("FAIL logic_flags[%0d]: got %b want %b", i, {negative, zero, overflow, carry_out}, tf[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore_and_back_to_back();
        int nb, lat; logic fb;
        run_op(64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 3'b110, 20, nb, lat, fb);
        n_cmp++;
        if (lat !== 64) begin n_mis++; $display("FAIL ignore_latency: got %0d want 64", lat); end
        n_cmp++;
        if (result !== 64'h0FF0_0FF0_0FF0_0FF0) begin
            n_mis++; $display("FAIL ignore_result: got %h want 0ff00ff00ff00ff0", result);
        end
        n_cmp++;
        if ({negative, zero, overflow, carry_out} !== 4'b0000) begin
            n_mis++; $display("FAIL xor_flags: got %b want 0000", {negative, zero, overflow, carry_out});
        end
        // Still in DONE: start asserted now must be taken on the very next edge.
        run_op(64'd100, 64'd58, 3'b011, -1, nb, lat, fb);
        n_cmp++;
        if (fb !== 1'b1) begin n_mis++; $display("FAIL b2b_no_gap: busy got %b want 1", fb); end
        n_cmp++;
        if (lat !== 64) begin n_mis++; $display("FAIL b2b_latency: got %0d want 64", lat); end
        n_cmp++;
        if (result !== 64'd42) begin n_mis++; $display("FAIL b2b_result: got %h want 2a", result); end
        n_cmp++;
        if ({negative, zero, overflow, carry_out} !== 4'b0001) begin
            n_mis++; $display("FAIL b2b_flags: got %b want 0001", {negative, zero, overflow, carry_out});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int nb, lat, n_done, n_busy; logic fb;
        A = 64'd1; B = 64'd1; cntrl = 3'b010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, negative, zero, overflow, carry_out} !== 6'b0) begin
            n_mis++;
            $display("FAIL abort_ctrl_flags: got %b want 000000", {busy, done, negative, zero, overflow, carry_out});
        end
        n_cmp++;
        if (result !== 64'h0) begin n_mis++; $display("FAIL abort_result: got %h want 0", result); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        n_done = 0; n_busy = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
            if (busy) n_busy++;
        end
        n_cmp++;
        if (n_done !== 0) begin n_mis++; $display("FAIL abort_no_done: got %0d pulses want 0", n_done); end
        n_cmp++;
        if (n_busy !== 0) begin n_mis++; $display("FAIL abort_no_busy: got %0d cycles want 0", n_busy); end
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 3'b000, -1, nb, lat, fb);
        n_cmp++;
        if (lat !== 64) begin n_mis++; $display("FAIL passb_latency: got %0d want 64", lat); end
        n_cmp++;
        if (result !== 64'h1234) begin n_mis++; $display("FAIL passb_result: got %h want 1234", result); end
        n_cmp++;
        if ({negative, zero, overflow, carry_out} !== 4'b0000) begin
            n_mis++; $display("FAIL passb_flags: got %b want 0000", {negative, zero, overflow, carry_out});
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_zero();
        test_overflow_borrow();
        test_logic_ops();
        test_ignore_and_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
